// File: rtl/pu_seq.sv
`default_nettype none
// ============================================================================
// Module   : pu_seq
// Function : Layer sequencer for the PU: issues one MAC op per accepted beat,
//            delays result writes by MAC_LAT and pulses finish at layer end.
// Revision : 1.0
// ============================================================================
module pu_seq #(
  parameter int WADDR_WIDTH = 7,
  parameter int RADDR_WIDTH = 6,
  parameter int CNT_WIDTH   = 8,
  parameter int MAC_LAT     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_start,
  input  logic [CNT_WIDTH-1:0]   in_num_chunks,
  input  logic [CNT_WIDTH-1:0]   in_num_outputs,
  input  logic                   in_add_bias,
  input  logic                   in_relu,
  input  logic                   in_data_valid,
  output logic                   out_data_ready,
  output logic                   out_mac_en,
  output logic [WADDR_WIDTH-1:0] out_w_rd_addr,
  output logic [2:0]             out_bias_addr,
  output logic                   out_add_bias,
  output logic                   out_relu,
  output logic                   out_done,
  output logic                   out_r_rd_en,
  output logic [RADDR_WIDTH-1:0] out_r_rd_addr,
  output logic                   out_r_wr_en,
  output logic [RADDR_WIDTH-1:0] out_r_wr_addr,
  output logic                   out_busy,
  output logic                   out_finish
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  // Write-delay stages that must be empty before the last write is on the bus
  localparam logic [MAC_LAT-1:0] LAT_MASK = {MAC_LAT{1'b1}} >> 1;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   num_c_q, num_o_q;
  logic                   lat_bias_q, lat_relu_q;
  logic [CNT_WIDTH-1:0]   c_q, c_d, o_q, o_d;
  logic [WADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                   load;

  logic                   mac_en_q;
  logic [WADDR_WIDTH-1:0] op_waddr_q;
  logic [2:0]             op_bias_addr_q;
  logic                   op_add_bias_q, op_relu_q, op_done_q, op_rd_en_q;
  logic [RADDR_WIDTH-1:0] op_raddr_q;

  logic [MAC_LAT-1:0]     wv_q;
  logic [RADDR_WIDTH-1:0] wa_q [MAC_LAT];

  logic accept, last_chunk, last_op, pending;

  assign accept     = (state_q == S_RUN) && in_data_valid;
  assign last_chunk = (c_q == num_c_q - CNT_WIDTH'(1));
  assign last_op    = last_chunk && (o_q == num_o_q - CNT_WIDTH'(1));
  // Writes still in flight after the current cycle
  assign pending    = mac_en_q | (|(wv_q & LAT_MASK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    o_d     = o_q;
    waddr_d = waddr_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          load    = 1'b1;
          c_d     = '0;
          o_d     = '0;
          waddr_d = '0;
          if (in_num_chunks == '0 || in_num_outputs == '0) state_d = S_FIN;
          else                                              state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          waddr_d = waddr_q + WADDR_WIDTH'(1);
          if (last_chunk) begin
            c_d = '0;
            o_d = o_q + CNT_WIDTH'(1);
          end else begin
            c_d = c_q + CNT_WIDTH'(1);
          end
          if (last_op) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (!pending) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_c_q        <= '0;
      num_o_q        <= '0;
      lat_bias_q     <= 1'b0;
      lat_relu_q     <= 1'b0;
      c_q            <= '0;
      o_q            <= '0;
      waddr_q        <= '0;
      mac_en_q       <= 1'b0;
      op_waddr_q     <= '0;
      op_bias_addr_q <= '0;
      op_add_bias_q  <= 1'b0;
      op_relu_q      <= 1'b0;
      op_done_q      <= 1'b0;
      op_rd_en_q     <= 1'b0;
      op_raddr_q     <= '0;
      wv_q           <= '0;
      for (int i = 0; i < MAC_LAT; i++) wa_q[i] <= '0;
    end else begin
      c_q     <= c_d;
      o_q     <= o_d;
      waddr_q <= waddr_d;
      if (load) begin
        num_c_q    <= in_num_chunks;
        num_o_q    <= in_num_outputs;
        lat_bias_q <= in_add_bias;
        lat_relu_q <= in_relu;
      end
      mac_en_q       <= accept;
      op_waddr_q     <= accept ? waddr_q : '0;
      op_bias_addr_q <= accept ? o_q[2:0] : 3'd0;
      op_done_q      <= accept && last_chunk;
      op_add_bias_q  <= accept && last_chunk && lat_bias_q;
      op_relu_q      <= accept && last_chunk && lat_relu_q;
      op_rd_en_q     <= accept && (c_q != '0);
      op_raddr_q     <= accept ? o_q[RADDR_WIDTH-1:0] : '0;
      // Write strobe/address follow the issued op by MAC_LAT cycles
      wv_q[0] <= mac_en_q;
      wa_q[0] <= op_raddr_q;
      for (int i = 1; i < MAC_LAT; i++) begin
        wv_q[i] <= wv_q[i-1];
        wa_q[i] <= wa_q[i-1];
      end
    end
  end

  assign out_data_ready = (state_q == S_RUN);
  assign out_busy       = (state_q != S_IDLE);
  assign out_finish     = (state_q == S_FIN);
  assign out_mac_en     = mac_en_q;
  assign out_w_rd_addr  = op_waddr_q;
  assign out_bias_addr  = op_bias_addr_q;
  assign out_add_bias   = op_add_bias_q;
  assign out_relu       = op_relu_q;
  assign out_done       = op_done_q;
  assign out_r_rd_en    = op_rd_en_q;
  assign out_r_rd_addr  = op_raddr_q;
  assign out_r_wr_en    = wv_q[MAC_LAT-1];
  assign out_r_wr_addr  = wa_q[MAC_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_pu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pu_seq
// Function : Self-checking bench for pu_seq against a loop-level layer model.
// Revision : 1.0
// ============================================================================
module tb_pu_seq;
  localparam int MAC_LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_start, in_add_bias, in_relu, in_data_valid;
  logic [7:0] in_num_chunks, in_num_outputs;
  logic       out_data_ready, out_mac_en, out_add_bias, out_relu, out_done;
  logic       out_r_rd_en, out_r_wr_en, out_busy, out_finish;
  logic [6:0] out_w_rd_addr;
  logic [2:0] out_bias_addr;
  logic [5:0] out_r_rd_addr, out_r_wr_addr;

  int n_checks = 0;
  int n_pass   = 0;

  pu_seq #(.WADDR_WIDTH(7), .RADDR_WIDTH(6), .CNT_WIDTH(8), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_start(in_start),
    .in_num_chunks(in_num_chunks), .in_num_outputs(in_num_outputs),
    .in_add_bias(in_add_bias), .in_relu(in_relu), .in_data_valid(in_data_valid),
    .out_data_ready(out_data_ready), .out_mac_en(out_mac_en),
    .out_w_rd_addr(out_w_rd_addr), .out_bias_addr(out_bias_addr),
    .out_add_bias(out_add_bias), .out_relu(out_relu), .out_done(out_done),
    .out_r_rd_en(out_r_rd_en), .out_r_rd_addr(out_r_rd_addr),
    .out_r_wr_en(out_r_wr_en), .out_r_wr_addr(out_r_wr_addr),
    .out_busy(out_busy), .out_finish(out_finish)
  );

  always #5 clk = ~clk;

  // Field order: ready, mac_en, waddr, bias_addr, add_bias, relu, done,
  // rd_en, rd_addr, wr_en, wr_addr, busy, finish
  function automatic logic [30:0] dut_vec();
    return {out_data_ready, out_mac_en, out_w_rd_addr, out_bias_addr,
            out_add_bias, out_relu, out_done, out_r_rd_en, out_r_rd_addr,
            out_r_wr_en, out_r_wr_addr, out_busy, out_finish};
  endfunction

  // Drives one layer from cycle 0 (start) and compares every cycle's outputs
  // with a model built from the nested chunk/output loop.
  // mode 0: valid always high, 1: valid low in cycles 2-3, 2: random valid
  // plus random start/parameter noise while busy.
  task automatic run_layer(input int C, input int N, input bit b, input bit r,
                           input int mode, output int fin_seen);
    int total = C * N;
    int issued = 0;
    int fin = (total == 0) ? 1 : 32'h3fffffff;
    int op_at[int];
    bit ended = 0;
    logic [30:0] exp_v;
    fin_seen = -1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      begin
        bit  e_ready, e_mac, e_ab, e_rl, e_dn, e_rde, e_wre;
        logic [6:0] e_wa;
        logic [2:0] e_ba;
        logic [5:0] e_rda, e_wra;
        e_ready = (k >= 1) && (issued < total);
        {e_mac, e_ab, e_rl, e_dn, e_rde, e_wre} = '0;
        e_wa = '0; e_ba = '0; e_rda = '0; e_wra = '0;
        if (op_at.exists(k)) begin
          int j = op_at[k];
          int c = j % C;
          int o = j / C;
          e_mac = 1;
          e_wa  = 7'(j % 128);
          e_ba  = 3'(o % 8);
          e_dn  = (c == C - 1);
          e_ab  = b && e_dn;
          e_rl  = r && e_dn;
          e_rde = (c != 0);
          e_rda = 6'(o % 64);
        end
        if (op_at.exists(k - MAC_LAT)) begin
          e_wre = 1;
          e_wra = 6'((op_at[k - MAC_LAT] / C) % 64);
        end
        exp_v = {e_ready, e_mac, e_wa, e_ba, e_ab, e_rl, e_dn, e_rde, e_rda,
                 e_wre, e_wra, (k >= 1 && k <= fin), (k == fin)};
        n_checks++;
        if (dut_vec() !== exp_v)
          $display("FAIL layer C=%0d N=%0d cycle %0d: outputs got %h expected %h",
                   C, N, k, dut_vec(), exp_v);
        else n_pass++;
        if (out_finish && fin_seen < 0) fin_seen = k;
        if (k == fin + 1) begin
          ended = 1;
          in_start = 0; in_data_valid = 0;
          break;
        end
        in_start       = (k == 0) || (mode == 2 && k < fin && $urandom_range(0, 3) == 0);
        in_num_chunks  = (k == 0) ? 8'(C) : 8'($urandom);
        in_num_outputs = (k == 0) ? 8'(N) : 8'($urandom);
        in_add_bias    = (k == 0) ? b : 1'($urandom);
        in_relu        = (k == 0) ? r : 1'($urandom);
        case (mode)
          0:       in_data_valid = 1;
          1:       in_data_valid = !(k == 2 || k == 3);
          default: in_data_valid = ($urandom_range(0, 3) != 0);
        endcase
        if (e_ready && in_data_valid) begin
          op_at[k + 1] = issued;
          issued++;
          if (issued == total) fin = k + 2 + MAC_LAT;
        end
      end
    end
    if (!ended) begin
      n_checks++;
      $display("FAIL layer C=%0d N=%0d timeout: finished got 0 expected 1", C, N);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; in_start = 0; in_num_chunks = 0; in_num_outputs = 0;
    in_add_bias = 0; in_relu = 0; in_data_valid = 0;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== 31'd0) $display("FAIL reset_state: got %h expected 0", dut_vec());
      else n_pass++;
    end
    rst_n = 1;
  endtask

  task automatic test_basic();
    int f;
    run_layer(3, 2, 1, 1, 0, f);
    n_checks++;
    if (f !== 10) $display("FAIL basic_finish_cycle: got %0d expected 10", f);
    else n_pass++;
  endtask

  task automatic test_stall();
    int f;
    run_layer(3, 2, 1, 1, 1, f);
    n_checks++;
    if (f !== 12) $display("FAIL stall_finish_cycle: got %0d expected 12", f);
    else n_pass++;
  endtask

  task automatic test_empty();
    int f;
    run_layer(0, 4, 1, 0, 0, f);
    n_checks++;
    if (f !== 1) $display("FAIL empty_c_finish: got %0d expected 1", f);
    else n_pass++;
    run_layer(5, 0, 0, 1, 0, f);
    n_checks++;
    if (f !== 1) $display("FAIL empty_n_finish: got %0d expected 1", f);
    else n_pass++;
  endtask

  task automatic test_single_chunk();
    int f;
    run_layer(1, 10, 0, 1, 0, f);
  endtask

  task automatic test_waddr_wrap();
    int f;
    run_layer(130, 1, 1, 0, 0, f);
  endtask

  task automatic test_random();
    int f;
    for (int t = 0; t < 8; t++)
      run_layer($urandom_range(1, 5), $urandom_range(1, 6), 1'($urandom),
                1'($urandom), 2, f);
  endtask

  task automatic test_reset_abort();
    int f;
    @(negedge clk);
    in_start = 1; in_num_chunks = 3; in_num_outputs = 4;
    in_add_bias = 1; in_relu = 1; in_data_valid = 1;
    @(negedge clk);
    in_start = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    n_checks++;
    if (dut_vec() !== 31'd0) $display("FAIL abort_reset_outputs: got %h expected 0", dut_vec());
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (dut_vec() !== 31'd0) $display("FAIL abort_reset_hold: got %h expected 0", dut_vec());
    else n_pass++;
    rst_n = 1; in_data_valid = 0;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== 31'd0) $display("FAIL abort_idle_no_finish: got %h expected 0", dut_vec());
      else n_pass++;
    end
    run_layer(2, 3, 1, 0, 0, f);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_empty();
    test_single_chunk();
    test_waddr_wrap();
    test_random();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
